// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared 16-entry register-file write port.
// Optional macro REGFILE_R0_PROTECT_EN suppresses writes to R0 and flags them on prot_err.
module regfile_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [4*NREQ-1:0]        req_sel,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  input  logic                     stall,
  output logic [NREQ-1:0]          gnt,
  output logic [15:0]              wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     prot_err
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [PW-1:0]      ptr_r;
  logic [PW-1:0]      win_s;
  logic               found_s;
  logic               load_s;
  int                 idx_s;
  logic [3:0]         sel_s;
  logic [NREQ-1:0]    gnt_s;
  logic [15:0]        wr_en_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic               prot_s;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_s = (int'(ptr_r) + i) % NREQ;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic and the values latched on entering WRITE.
  always_comb begin
    state_s   = IDLE;
    load_s    = 1'b0;
    sel_s     = req_sel[4*int'(win_s) +: 4];
    wr_data_s = req_data[DATA_W*int'(win_s) +: DATA_W];
    gnt_s     = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    wr_en_s   = 16'h0001 << sel_s;
    prot_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!stall && found_s) begin
          state_s = WRITE;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
`ifdef REGFILE_R0_PROTECT_EN
    // R0 is hard-wired; the grant still goes out so the requester retires.
    if (sel_s == 4'd0) begin
      wr_en_s = 16'h0000;
      prot_s  = 1'b1;
    end else begin
      prot_s  = 1'b0;
    end
`endif
  end

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ptr_r    <= PW'(NREQ-1);
      gnt      <= '0;
      wr_en    <= 16'h0000;
      wr_data  <= '0;
      busy     <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        ptr_r    <= win_s;
        gnt      <= gnt_s;
        wr_en    <= wr_en_s;
        wr_data  <= wr_data_s;
        busy     <= 1'b1;
        prot_err <= prot_s;
      end else begin
        ptr_r    <= ptr_r;
        gnt      <= '0;
        wr_en    <= 16'h0000;
        wr_data  <= '0;
        busy     <= 1'b0;
        prot_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, select sweep and
// hand-written reset/stall/fairness sequences feeding a scoreboard queue.
module tb_regfile_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [4*NREQ-1:0]      req_sel;
  logic [DATA_W*NREQ-1:0] req_data;
  logic                   stall;
  logic [NREQ-1:0]        gnt;
  logic [15:0]            wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic                   busy;
  logic                   prot_err;

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_data(req_data),
    .stall(stall), .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] wr_en;
    logic [31:0] data;
    logic        busy;
    logic        prot;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic        stall;
    logic [3:0]  exp_gnt;
    logic [15:0] exp_wr_en;
    logic [31:0] exp_data;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  localparam logic [15:0]  SEL_DEF  = 16'hFA51;
  localparam logic [127:0] DATA_DEF = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [15:0] w, input logic [31:0] d, input logic p);
    exp_t e;
    e.gnt = g; e.wr_en = w; e.data = d; e.prot = p;
    e.busy = (g != 4'b0000);
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got gnt %b expected an entry", tag, gnt);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".gnt"},      32'(gnt),      32'(e.gnt));
      chk({tag, ".wr_en"},    32'(wr_en),    32'(e.wr_en));
      chk({tag, ".wr_data"},  wr_data,       e.data);
      chk({tag, ".busy"},     32'(busy),     32'(e.busy));
      chk({tag, ".prot_err"}, 32'(prot_err), 32'(e.prot));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    push(4'b0000, 16'h0000, 32'h0, 1'b0);
    tick();
    pop_check(tag);
  endtask

  initial begin
    logic [3:0]  fsel[4];
    logic [31:0] fdat[4];
    logic [15:0] w;
    logic        p;

    // Pointer starts at 3 after reset; sels r0=1 r1=5 r2=A r3=F.
    vecs[0] = '{4'b0100, 1'b0, 4'b0100, 16'h0400, 32'hDEADBEEF};
    vecs[1] = '{4'b1011, 1'b0, 4'b1000, 16'h8000, 32'h44444444};
    vecs[2] = '{4'b1001, 1'b0, 4'b0001, 16'h0002, 32'h11111111};
    vecs[3] = '{4'b1001, 1'b0, 4'b1000, 16'h8000, 32'h44444444};
    vecs[4] = '{4'b0110, 1'b0, 4'b0010, 16'h0020, 32'h22222222};
    vecs[5] = '{4'b0110, 1'b0, 4'b0100, 16'h0400, 32'hDEADBEEF};
    vecs[6] = '{4'b0000, 1'b0, 4'b0000, 16'h0000, 32'h00000000};
    vecs[7] = '{4'b0011, 1'b1, 4'b0000, 16'h0000, 32'h00000000};
    vecs[8] = '{4'b0011, 1'b0, 4'b0001, 16'h0002, 32'h11111111};
    fsel = '{4'h1, 4'h5, 4'hA, 4'hF};
    fdat = '{32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444};

    rst_n    = 1'b0;
    req      = 4'b0000;
    stall    = 1'b0;
    req_sel  = SEL_DEF;
    req_data = DATA_DEF;
    #12;
    push(4'b0000, 16'h0000, 32'h0, 1'b0);
    pop_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      req   = vecs[i].req;
      stall = vecs[i].stall;
      push(vecs[i].exp_gnt, vecs[i].exp_wr_en, vecs[i].exp_data, 1'b0);
      tick();
      pop_check($sformatf("vec%0d", i));
      if (vecs[i].exp_gnt != 4'b0000) begin
        req   = 4'b0000;
        stall = 1'b0;
        idle_cycle($sformatf("vec%0d_after", i));
      end
    end

    for (int s = 0; s < 16; s++) begin
      req_sel = {4'hF, 4'hA, 4'(s), 4'h1};
      req     = 4'b0010;
      w       = 16'h0001 << s;
      p       = 1'b0;
`ifdef REGFILE_R0_PROTECT_EN
      if (s == 0) begin
        w = 16'h0000;
        p = 1'b1;
      end
`endif
      push(4'b0010, w, 32'h22222222, p);
      tick();
      pop_check($sformatf("sweep%0d", s));
      req = 4'b0000;
      idle_cycle($sformatf("sweep%0d_after", s));
    end
    req_sel = SEL_DEF;

    req   = 4'b0010;
    stall = 1'b1;
    for (int c = 0; c < 5; c++) idle_cycle($sformatf("stall%0d", c));
    stall = 1'b0;
    push(4'b0010, 16'h0020, 32'h22222222, 1'b0);
    tick();
    stall = 1'b1;
    req   = 4'b0000;
    #1;
    pop_check("stall_write");
    stall = 1'b0;
    idle_cycle("stall_after");

    // Abandon a write by asserting reset in the middle of WRITE.
    req = 4'b1111;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push(4'b0000, 16'h0000, 32'h0, 1'b0);
    pop_check("async_reset");
    #1;
    rst_n = 1'b1;
    push(4'b0001, 16'h0002, 32'h11111111, 1'b0);
    tick();
    pop_check("post_reset");

    for (int k = 1; k <= 4; k++) begin
      idle_cycle($sformatf("fair_gap%0d", k));
      push(4'b0001 << (k % 4), 16'h0001 << fsel[k % 4], fdat[k % 4], 1'b0);
      tick();
      pop_check($sformatf("fair%0d", k));
    end
    req = 4'b0000;
    idle_cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
